// File: rtl/mips_dmem_responder_pkg.sv
// Shared constants and types for the MIPS data-memory responder.
// Address map, timer register select and CTRL layout live here so the top and timer agree.
package mips_dmem_responder_pkg;

  localparam logic [31:0] LED_ADDR  = 32'hFFFF_0000;
  localparam logic [31:0] SW_ADDR   = 32'hFFFF_0004;
  localparam logic [31:0] CNT_ADDR  = 32'hFFFF_0010;
  localparam logic [31:0] CMP_ADDR  = 32'hFFFF_0014;
  localparam logic [31:0] CTRL_ADDR = 32'hFFFF_0018;
  localparam logic [31:0] STAT_ADDR = 32'hFFFF_001C;
  localparam logic [31:0] CMP_RST   = 32'hFFFF_FFFF;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_AR  = 1;
  localparam int CTRL_IRQ = 2;

  // Timer register picked by addr[3:2] inside the 0xFFFF_001x window
  typedef enum logic [1:0] {
    TR_CNT  = 2'd0,
    TR_CMP  = 2'd1,
    TR_CTRL = 2'd2,
    TR_STAT = 2'd3
  } tmr_reg_e;

  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic enable;
  } tmr_ctrl_t;

endpackage

// File: rtl/mips_dmem_responder_if.sv
// CPU data-memory port: write strobe, byte address, write data, zero-latency read data.
interface mips_dmem_responder_if;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;

  modport master (output memwrite, memaddr, memwritedata, input memreaddata);
  modport slave  (input memwrite, memaddr, memwritedata, output memreaddata);
endinterface

// File: rtl/mips_dmem_responder_mmio_timer.sv
// 32-bit compare timer: CNT/CMP/CTRL/STAT with W1C match flag and level irq.
// Write port commits on posedge; read port is combinational from registered state.
module mips_dmem_responder_mmio_timer
  import mips_dmem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  tmr_reg_e    addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [31:0] cnt, cmp;
  tmr_ctrl_t   ctrl;
  logic        match;
  logic        hit, wr;

  // Compare always uses registered CMP, so a same-cycle CMP write only affects the next edge
  assign hit = ctrl.enable && (cnt == cmp);
  assign wr  = sel && we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      cmp   <= CMP_RST;
      ctrl  <= '0;
      match <= 1'b0;
    end else begin
      if (ctrl.enable)
        cnt <= (hit && ctrl.auto_reload) ? 32'd0 : cnt + 32'd1;
      if (wr && addr == TR_CNT)  cnt  <= wdata;
      if (wr && addr == TR_CMP)  cmp  <= wdata;
      if (wr && addr == TR_CTRL) ctrl <= tmr_ctrl_t'(wdata[2:0]);
      // A new match beats a simultaneous clear
      if (hit)
        match <= 1'b1;
      else if (wr && addr == TR_STAT && wdata[0])
        match <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      TR_CNT:  rdata = cnt;
      TR_CMP:  rdata = cmp;
      TR_CTRL: rdata = {29'd0, ctrl};
      TR_STAT: rdata = {31'd0, match};
      default: rdata = '0;
    endcase
  end

  assign irq = match && ctrl.irq_en;

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the single-cycle MIPS core: word RAM, LED register,
// synchronised switches and compare timer behind a zero-latency read mux.
module mips_dmem_responder
  import mips_dmem_responder_pkg::*;
#(
  parameter int RAM_AW = 6,
  parameter int LED_W  = 8,
  parameter int SW_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_dmem_responder_if.slave bus,
  input  logic [SW_W-1:0]      switches,
  output logic [LED_W-1:0]     leds,
  output logic                 timer_irq
);

  logic [31:0]       ram [2**RAM_AW];
  logic [RAM_AW-1:0] widx;
  logic [29:0]       waddr;
  logic              ram_hit, tmr_sel, led_hit, sw_hit;
  logic [SW_W-1:0]   sw_sync [2];
  logic [31:0]       tmr_rdata, rd;
  logic              unused_addr;

  assign unused_addr = ^bus.memaddr[1:0];
  assign waddr       = bus.memaddr[31:2];
  assign widx        = bus.memaddr[RAM_AW+1:2];
  // Only the low 2**RAM_AW words decode as RAM; anything above reads 0 instead of aliasing
  assign ram_hit = (bus.memaddr[31:28] == 4'h0) && ((bus.memaddr[27:2] >> RAM_AW) == 26'd0);
  assign tmr_sel = (bus.memaddr[31:4] == CNT_ADDR[31:4]);
  assign led_hit = (waddr == LED_ADDR[31:2]);
  assign sw_hit  = (waddr == SW_ADDR[31:2]);

  // RAM has no reset so its contents survive a mid-run reset
  always_ff @(posedge clk) begin
    if (bus.memwrite && ram_hit)
      ram[widx] <= bus.memwritedata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds       <= '0;
      sw_sync[0] <= '0;
      sw_sync[1] <= '0;
    end else begin
      if (bus.memwrite && led_hit)
        leds <= bus.memwritedata[LED_W-1:0];
      sw_sync[0] <= switches;
      sw_sync[1] <= sw_sync[0];
    end
  end

  mips_dmem_responder_mmio_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .sel   (tmr_sel),
    .we    (bus.memwrite),
    .addr  (tmr_reg_e'(bus.memaddr[3:2])),
    .wdata (bus.memwritedata),
    .rdata (tmr_rdata),
    .irq   (timer_irq)
  );

  always_comb begin
    rd = '0;
    if (ram_hit)      rd = ram[widx];
    else if (tmr_sel) rd = tmr_rdata;
    else if (led_hit) rd = 32'(leds);
    else if (sw_hit)  rd = 32'(sw_sync[1]);
  end

  assign bus.memreaddata = rd;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Self-checking bench: vector table for map/RAM/reset state, hand sequences for switches,
// timer match/reload, W1C races and asynchronous reset. Read results go through a scoreboard.
module tb_mips_dmem_responder;
  import mips_dmem_responder_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] switches;
  logic [7:0] leds;
  logic       timer_irq;

  mips_dmem_responder_if bus();

  mips_dmem_responder #(.RAM_AW(6), .LED_W(8), .SW_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .switches  (switches),
    .leds      (leds),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct { string name; logic [31:0] exp; } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one bus cycle from posedge+1; read data sampled at negedge; ends at next posedge+1.
  task automatic bus_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic chk, input logic [31:0] exp, input string name);
    sb_t e;
    bus.memwrite     = we;
    bus.memaddr      = addr;
    bus.memwritedata = wdata;
    if (chk) begin
      e.name = name;
      e.exp  = exp;
      sbq.push_back(e);
    end
    @(negedge clk);
    if (chk) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: scoreboard empty", name);
      end else begin
        e = sbq.pop_front();
        check(e.name, bus.memreaddata, e.exp);
      end
    end
    @(posedge clk);
    #1;
    bus.memwrite = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus_op(1'b1, addr, data, 1'b0, 32'd0, "wr");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    bus_op(1'b0, addr, 32'd0, 1'b1, exp, name);
  endtask

  task automatic addv(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic chk, input logic [31:0] exp, input string name);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.chk = chk; v.exp = exp; v.name = name;
    vt.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset            = 1'b1;
    switches         = 8'h00;
    bus.memwrite     = 1'b0;
    bus.memaddr      = 32'd0;
    bus.memwritedata = 32'd0;

    // Vector table: reset state, RAM, LED, unmapped, RAM boundary, CTRL/STAT masking
    addv(0, CNT_ADDR,      0,            1, 32'h0000_0000, "rst_cnt");
    addv(0, CMP_ADDR,      0,            1, 32'hFFFF_FFFF, "rst_cmp");
    addv(0, CTRL_ADDR,     0,            1, 32'h0000_0000, "rst_ctrl");
    addv(0, STAT_ADDR,     0,            1, 32'h0000_0000, "rst_stat");
    addv(0, LED_ADDR,      0,            1, 32'h0000_0000, "rst_led");
    addv(0, SW_ADDR,       0,            1, 32'h0000_0000, "rst_sw");
    addv(1, 32'h0000_0008, 32'hDEAD_BEEF, 0, 32'h0,        "ram_wr8");
    addv(0, 32'h0000_0008, 0,            1, 32'hDEAD_BEEF, "ram_rd8");
    addv(0, 32'h0000_000A, 0,            1, 32'hDEAD_BEEF, "ram_rdA");
    addv(1, LED_ADDR,      32'h0000_01A5, 0, 32'h0,        "led_wr");
    addv(0, LED_ADDR,      0,            1, 32'h0000_00A5, "led_rd");
    addv(0, 32'h2000_0000, 0,            1, 32'h0000_0000, "unmap_rd");
    addv(1, 32'h2000_0000, 32'h1234_5678, 0, 32'h0,        "unmap_wr");
    addv(0, 32'h2000_0000, 0,            1, 32'h0000_0000, "unmap_rd2");
    addv(1, 32'h0000_0000, 32'hAAAA_5555, 0, 32'h0,        "ram_wr0");
    addv(1, 32'h0000_00FC, 32'h1122_3344, 0, 32'h0,        "ram_wrlast");
    addv(1, 32'h0000_0100, 32'h0BAD_0BAD, 0, 32'h0,        "ram_wrpast");
    addv(0, 32'h0000_0000, 0,            1, 32'hAAAA_5555, "ram_noalias");
    addv(0, 32'h0000_00FC, 0,            1, 32'h1122_3344, "ram_rdlast");
    addv(0, 32'h0000_0100, 0,            1, 32'h0000_0000, "ram_rdpast");
    addv(0, 32'h1000_0000, 0,            1, 32'h0000_0000, "hi_nibble");
    addv(1, CTRL_ADDR,     32'hFFFF_FFF8, 0, 32'h0,        "ctrl_wrhi");
    addv(0, CTRL_ADDR,     0,            1, 32'h0000_0000, "ctrl_mask");
    addv(1, CTRL_ADDR,     32'h0000_0006, 0, 32'h0,        "ctrl_wr6");
    addv(0, CTRL_ADDR,     0,            1, 32'h0000_0006, "ctrl_rd6");
    addv(1, CTRL_ADDR,     32'h0000_0000, 0, 32'h0,        "ctrl_wr0");

    #12;
    check("rst_leds_async", 32'(leds), 32'h0);
    check("rst_irq", 32'(timer_irq), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (vt[i])
      bus_op(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].chk, vt[i].exp, vt[i].name);
    check("leds_pin", 32'(leds), 32'h0000_00A5);

    // Switch synchroniser: 0 for two samples after the change, value on the third
    switches = 8'h3C;
    rd(SW_ADDR, 32'h0, "sw_t0");
    rd(SW_ADDR, 32'h0, "sw_t1");
    rd(SW_ADDR, 32'h3C, "sw_t2");

    // Timer with auto_reload: match on 6th enabled edge, CNT back to 0
    wr(CMP_ADDR, 32'd5);
    wr(CNT_ADDR, 32'd0);
    wr(CTRL_ADDR, 32'h7);
    for (int i = 1; i <= 6; i++) begin
      rd(CNT_ADDR, 32'(i - 1), "ar_cnt");
      check("ar_irq", 32'(timer_irq), (i == 6) ? 32'h1 : 32'h0);
    end
    rd(CNT_ADDR, 32'd0, "ar_reload");
    rd(STAT_ADDR, 32'd1, "ar_stat");

    // Same again without auto_reload: count runs through the match
    wr(CTRL_ADDR, 32'h0);
    wr(CNT_ADDR, 32'd0);
    wr(STAT_ADDR, 32'd1);
    check("w1c_quiet_irq", 32'(timer_irq), 32'h0);
    wr(CTRL_ADDR, 32'h5);
    for (int i = 1; i <= 6; i++)
      rd(CNT_ADDR, 32'(i - 1), "nr_cnt");
    rd(CNT_ADDR, 32'd6, "nr_cnt6");
    rd(CNT_ADDR, 32'd7, "nr_cnt7");
    rd(STAT_ADDR, 32'd1, "nr_stat");
    check("nr_irq", 32'(timer_irq), 32'h1);

    // W1C racing a new match: set wins; W1C in a quiet cycle clears
    wr(CTRL_ADDR, 32'h0);
    wr(CMP_ADDR, 32'd2);
    wr(CNT_ADDR, 32'd0);
    wr(STAT_ADDR, 32'd0);
    rd(STAT_ADDR, 32'd1, "w0_noeffect");
    wr(STAT_ADDR, 32'd1);
    wr(CTRL_ADDR, 32'h7);
    rd(CNT_ADDR, 32'd0, "race_cnt0");
    rd(CNT_ADDR, 32'd1, "race_cnt1");
    wr(STAT_ADDR, 32'd1);
    check("race_irq", 32'(timer_irq), 32'h1);
    rd(STAT_ADDR, 32'd1, "race_stat");
    wr(STAT_ADDR, 32'd1);
    check("clr_irq", 32'(timer_irq), 32'h0);
    rd(STAT_ADDR, 32'd0, "clr_stat");
    wr(CTRL_ADDR, 32'h0);

    // Asynchronous reset mid-count; RAM must survive
    wr(LED_ADDR, 32'h5A);
    wr(CMP_ADDR, 32'd2);
    wr(CNT_ADDR, 32'd0);
    wr(CTRL_ADDR, 32'h5);
    for (int i = 0; i < 5; i++) wr(32'h3000_0000, 32'd0);
    check("pre_rst_irq", 32'(timer_irq), 32'h1);
    check("pre_rst_leds", 32'(leds), 32'h5A);
    #2;
    reset = 1'b1;
    #1;
    check("arst_leds", 32'(leds), 32'h0);
    check("arst_irq", 32'(timer_irq), 32'h0);
    bus.memaddr = CNT_ADDR;  #1; check("arst_cnt", bus.memreaddata, 32'h0);
    bus.memaddr = CTRL_ADDR; #1; check("arst_ctrl", bus.memreaddata, 32'h0);
    bus.memaddr = STAT_ADDR; #1; check("arst_stat", bus.memreaddata, 32'h0);
    bus.memaddr = CMP_ADDR;  #1; check("arst_cmp", bus.memreaddata, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd(32'h0000_0008, 32'hDEAD_BEEF, "ram_keep8");
    rd(32'h0000_00FC, 32'h1122_3344, "ram_keeplast");
    rd(CNT_ADDR, 32'h0, "post_rst_cnt");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
